mem_responder: RTL
==================

Name: mem_responder

Overview:
Data-memory responder for the multi-cycle core: the target end of the core's memory-stage load/store request.
- Accepts one request at a time via a valid/ready handshake.
- Services it from an internal word-organised RAM after a fixed number of wait states.
- Returns a single-cycle response pulse that the core uses to leave the memory stage.
- Handles RV32 byte/halfword/word accesses with sign/zero extension and misalignment faults.

Parameters:
- ADDR_WIDTH, 10, number of word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 2, cycles spent in WAIT between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result, valid while rsp_valid; 0 for stores and faults.
- rsp_fault  output  1  access faulted, valid while rsp_valid.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - state = IDLE.
  - req_ready = 1 in the first cycle after reset.
  - rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0.
  - RAM contents are not cleared.
- States and transitions: IDLE, WAIT, RESPOND (one-hot or binary; implementer's choice).
  - IDLE: req_ready = 1. On req_valid at a clock edge:
    - latch write, addr, size, unsigned and wdata;
    - load wait counter = WAIT_STATES;
    - next state is WAIT if WAIT_STATES > 0, else RESPOND.
  - WAIT: req_ready = 0; counter decrements each cycle. When counter == 1, next state is RESPOND.
  - RESPOND: rsp_valid = 1 for exactly one cycle, req_ready = 0; next state is IDLE.
- Latency: a request accepted at edge T gives rsp_valid high in cycle T+WAIT_STATES+1. Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- Inputs are sampled only at the acceptance edge. Changes in req_* during WAIT or RESPOND are ignored. req_valid outside IDLE is ignored; no queueing.
- Fault condition: size == 3; or size == 1 with addr[0] == 1; or size == 2 with addr[1:0] != 0.
  - A faulting store does not modify RAM.
  - A faulting access returns rsp_rdata = 0 and rsp_fault = 1.
- Word index = addr[ADDR_WIDTH+1:2]; higher address bits are ignored (aliasing) unless the optional feature is enabled.
- Store: committed at the edge entering RESPOND, writing only the byte lanes selected by size and addr[1:0].
  - byte: wdata[7:0] goes to lane addr[1:0].
  - half: wdata[15:0] goes to lanes addr[1]*2 and addr[1]*2+1.
  - Other lanes are untouched.
- Load: rsp_rdata reflects RAM contents at the RESPOND cycle, shifted down by addr[1:0]*8. Byte/half results are extended per req_unsigned.
- Reset mid-operation: in WAIT, the request is abandoned and no RAM write occurs. In RESPOND, the rsp_valid pulse is suppressed from the next cycle, and an already-committed store stays committed. State returns to IDLE.

Optional Feature:
- MEM_RESPONDER_BOUNDS_CHECK_EN defined: any request with a nonzero req_addr[31:ADDR_WIDTH+2] also faults, with the same fault behaviour (no write, rdata 0, rsp_fault 1).
- Not defined: upper address bits are ignored and addresses alias modulo 2^(ADDR_WIDTH+2) bytes.

Test Plan:
- WAIT_STATES=2: store word 0xDEADBEEF at 0x10 accepted at edge T → rsp_valid only in cycle T+3, rsp_fault=0. Word load at 0x10 → rsp_rdata=0xDEADBEEF.
- Store byte 0x80 at 0x13, then load byte 0x13 signed → 0xFFFFFF80. Unsigned → 0x00000080. Word load 0x10 → 0x80ADBEEF.
- Half load at 0x11 → rsp_fault=1, rsp_rdata=0. Word store at 0x12 → fault, and a following word read of 0x10 still returns the prior value.
- req_valid held high continuously with WAIT_STATES=0 → req_ready high every other cycle; rsp_valid alternating with acceptances; no double acceptance.
- Reset asserted in WAIT of a word store to 0x20 → rsp_valid never asserts, RAM at 0x20 unchanged, req_ready=1 in the cycle after reset.
- Word load at 0x00001010 with ADDR_WIDTH=10 → returns the data at 0x10 without the macro; rsp_fault=1 and rsp_rdata=0 with MEM_RESPONDER_BOUNDS_CHECK_EN.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: target end of the core's memory-stage load/store request.
// Accepts one request at a time, waits WAIT_STATES cycles, then pulses a
// single-cycle response. Handles RV32 byte/half/word accesses with sign or
// zero extension and reports misaligned or illegal-size accesses as faults.
//
// Parameters:
//   ADDR_WIDTH  - word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words
//   WAIT_STATES - cycles spent in WAIT between acceptance and response (0..15)
//
// Ports:
//   clk, reset          - clock; synchronous active-high reset
//   req_valid/req_ready - request handshake (ready only while idle)
//   req_write           - 1 = store, 0 = load
//   req_addr            - byte address
//   req_size            - 0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned        - loads zero-extend when set, sign-extend otherwise
//   req_wdata           - right-aligned store data
//   rsp_valid           - one-cycle response pulse
//   rsp_rdata           - load result (0 for stores and faults)
//   rsp_fault           - access faulted
//
// Build option:
//   MEM_RESPONDER_BOUNDS_CHECK_EN - when defined, any nonzero address bit above
//   the RAM range faults; otherwise upper address bits alias.
module mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } mem_req_t;

    state_t   state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    mem_req_t in_req, lat, cur;

    logic [NUM_LANES-1:0][7:0] mem [DEPTH];

    logic [NUM_LANES-1:0]      be;
    logic [NUM_LANES-1:0][7:0] wd;
    logic                      commit;
    logic [NUM_LANES-1:0][7:0] rword;
    logic [31:0]               shifted, ext;
    logic                      lat_fault;

    function automatic logic access_fault(input mem_req_t r);
        logic f;
        case (r.size)
            2'd0:    f = 1'b0;
            2'd1:    f = r.addr[0];
            2'd2:    f = |r.addr[1:0];
            default: f = 1'b1;
        endcase
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        f = f | (|r.addr[31:ADDR_WIDTH+2]);
`endif
        return f;
    endfunction

    assign in_req = {req_write, req_addr, req_size, req_unsigned, req_wdata};

    // The store commits on the edge entering RESPOND. With zero wait states
    // that is the acceptance edge itself, so the live request must be used
    // before it has been latched.
    assign cur = (state == IDLE) ? in_req : lat;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    cnt_nxt   = 4'(WAIT_STATES);
                    state_nxt = (WAIT_STATES == 0) ? RESPOND : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = RESPOND;
            end
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) lat <= in_req;
    end

    // Lane enables and lane-replicated store data.
    always_comb begin
        be = '0;
        wd = '0;
        case (cur.size)
            2'd0: begin
                be[cur.addr[1:0]] = 1'b1;
                wd = {4{cur.wdata[7:0]}};
            end
            2'd1: begin
                be = cur.addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{cur.wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = cur.wdata;
            end
        endcase
    end

    // Reset on the commit edge abandons the store.
    assign commit = !reset && (state_nxt == RESPOND) && cur.write && !access_fault(cur);

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (be[i]) mem[cur.addr[ADDR_WIDTH+1:2]][i] <= wd[i];
            end
        end
    end

    assign lat_fault = access_fault(lat);
    assign rword     = mem[lat.addr[ADDR_WIDTH+1:2]];

    always_comb begin
        shifted = rword >> {lat.addr[1:0], 3'b000};
        case (lat.size)
            2'd0:    ext = lat.uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    ext = lat.uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESPOND);
    assign rsp_fault = (state == RESPOND) && lat_fault;
    assign rsp_rdata = (state == RESPOND && !lat.write && !lat_fault) ? ext : 32'd0;

    // Upper address bits only matter when bounds checking is built in.
    logic unused_bits;
    assign unused_bits = ^{lat.addr[31:ADDR_WIDTH+2], cur.addr[31:ADDR_WIDTH+2], cur.uns};

endmodule
